// File: rtl/priority_encoder_4_2_if.sv
// Request/presentation bundle for the registered 4-to-2 priority encoder.
// master drives requests and ack; slave is the encoder.
interface priority_encoder_4_2_if #(
   parameter int A_W = 2
);
   localparam int N = 2 ** A_W;

   logic           en;
   logic [N-1:0]   y;
   logic [A_W-1:0] a;
   logic           valid;
   logic           ack;
   logic [N-1:0]   pending;

   modport master (output en, y, ack, input a, valid, pending);
   modport slave  (input en, y, ack, output a, valid, pending);
endinterface

// File: rtl/priority_encoder_4_2.sv
// Registered priority encoder: latches requests as pending bits and presents
// the highest pending index, held stable until acknowledged.
module priority_encoder_4_2 #(
   parameter int A_W = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   priority_encoder_4_2_if.slave bus
);
   localparam int N = 2 ** A_W;

   localparam logic [0:0] IDLE    = 1'b0;
   localparam logic [0:0] PRESENT = 1'b1;

   logic [0:0]     state_q, state_d;
   logic [N-1:0]   pending_q, pending_d;
   logic [A_W-1:0] a_q, a_d;
   logic [N-1:0]   clr;
   logic [A_W-1:0] code;

   // Ascending scan: the last set bit seen is the highest index, so it wins.
   always_comb begin
      code = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (pending_q[i]) code = A_W'(i);
      end
   end

   // Set is OR-ed in after the clear so a same-cycle request survives its ack.
   always_comb begin
      clr = '0;
      if (state_q == PRESENT && bus.ack) clr[a_q] = 1'b1;
      pending_d = (pending_q & ~clr) | (bus.en ? bus.y : '0);
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      case (state_q)
         IDLE: begin
            if (pending_q != '0) begin
               a_d     = code;
               state_d = PRESENT;
            end
         end
         PRESENT: begin
            if (bus.ack) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         pending_q <= '0;
         a_q       <= '0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         a_q       <= a_d;
      end
   end

   assign bus.a       = a_q;
   assign bus.valid   = (state_q == PRESENT);
   assign bus.pending = pending_q;
endmodule

// File: tb/tb_priority_encoder_4_2.sv
// Scoreboard bench for priority_encoder_4_2: expected codes are queued when
// requests are driven and compared as the encoder presents them.
module tb_priority_encoder_4_2;
   logic clk = 1'b0;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;
   logic [1:0] exp_q[$];

   priority_encoder_4_2_if #(.A_W(2)) bus ();

   priority_encoder_4_2 #(.A_W(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Wait (bounded) for a presentation, compare against the queue head, ack it.
   task automatic serve(input string tag, output int gap);
      logic [1:0] exp;
      gap = 0;
      while (!bus.valid && gap < 10) begin
         tick();
         gap++;
      end
      if (exp_q.size() == 0) begin
         check_eq({tag, "_qempty"}, 32'd1, 32'd0);
         exp = 2'b00;
      end else begin
         exp = exp_q.pop_front();
      end
      if (!bus.valid) begin
         check_eq({tag, "_timeout"}, 32'd0, 32'd1);
      end else begin
         check_eq({tag, "_a"}, 32'(bus.a), 32'(exp));
         bus.ack = 1'b1;
         tick();
         bus.ack = 1'b0;
         check_eq({tag, "_valid_drop"}, 32'(bus.valid), 32'd0);
      end
   endtask

   initial begin
      int gap;
      rst_n   = 1'b0;
      bus.en  = 1'b0;
      bus.y   = 4'b0000;
      bus.ack = 1'b0;
      #12;
      check_eq("rst_valid", 32'(bus.valid), 32'd0);
      check_eq("rst_a", 32'(bus.a), 32'd0);
      check_eq("rst_pending", 32'(bus.pending), 32'd0);
      rst_n = 1'b1;
      tick();
      tick();
      check_eq("idle_valid", 32'(bus.valid), 32'd0);

      // Single request
      bus.en = 1'b1;
      bus.y  = 4'b0100;
      exp_q.push_back(2'b10);
      tick();
      bus.y = 4'b0000;
      check_eq("single_pending_k", 32'(bus.pending), 32'h4);
      check_eq("single_valid_k", 32'(bus.valid), 32'd0);
      tick();
      check_eq("single_valid_k1", 32'(bus.valid), 32'd1);
      serve("single", gap);
      check_eq("single_pending_clr", 32'(bus.pending), 32'h0);

      // Multi-hot priority, then preemption blocked while presenting code 0
      bus.y = 4'b1011;
      exp_q.push_back(2'b11);
      exp_q.push_back(2'b01);
      exp_q.push_back(2'b00);
      tick();
      bus.y = 4'b0000;
      check_eq("multi_pending0", 32'(bus.pending), 32'hB);
      serve("multi3", gap);
      check_eq("multi_pending1", 32'(bus.pending), 32'h3);
      serve("multi1", gap);
      check_eq("multi1_gap", 32'(gap), 32'd1);
      check_eq("multi_pending2", 32'(bus.pending), 32'h1);
      tick();
      check_eq("pre_valid", 32'(bus.valid), 32'd1);
      check_eq("pre_a0", 32'(bus.a), 32'd0);
      bus.y = 4'b1000;
      exp_q.push_back(2'b11);
      tick();
      bus.y = 4'b0000;
      check_eq("pre_a_frozen", 32'(bus.a), 32'd0);
      check_eq("pre_pending", 32'(bus.pending), 32'h9);
      serve("pre0", gap);
      check_eq("pre_pending_after", 32'(bus.pending), 32'h8);
      serve("pre3", gap);
      check_eq("pre3_gap", 32'(gap), 32'd1);
      check_eq("pre_pending_empty", 32'(bus.pending), 32'h0);

      // Enable gating
      bus.en = 1'b0;
      bus.y  = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         tick();
         check_eq("gate_pending", 32'(bus.pending), 32'h0);
         check_eq("gate_valid", 32'(bus.valid), 32'd0);
      end
      bus.en = 1'b1;
      bus.y  = 4'b0010;
      exp_q.push_back(2'b01);
      tick();
      bus.y = 4'b0000;
      serve("gate", gap);

      // Set beats clear: request held through the ack cycle re-arms
      bus.y = 4'b0010;
      exp_q.push_back(2'b01);
      tick();
      serve("sbc_first", gap);
      check_eq("sbc_pending_kept", 32'(bus.pending), 32'h2);
      bus.y = 4'b0000;
      exp_q.push_back(2'b01);
      serve("sbc_again", gap);
      check_eq("sbc_gap", 32'(gap), 32'd1);
      check_eq("sbc_pending_clr", 32'(bus.pending), 32'h0);

      // Asynchronous reset mid-presentation
      bus.y = 4'b1001;
      tick();
      bus.y = 4'b0000;
      tick();
      check_eq("arst_pre_valid", 32'(bus.valid), 32'd1);
      check_eq("arst_pre_a", 32'(bus.a), 32'd3);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("arst_valid", 32'(bus.valid), 32'd0);
      check_eq("arst_a", 32'(bus.a), 32'd0);
      check_eq("arst_pending", 32'(bus.pending), 32'h0);
      exp_q.delete();
      #5;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      check_eq("arst_idle_valid", 32'(bus.valid), 32'd0);
      check_eq("arst_idle_pending", 32'(bus.pending), 32'h0);
      check_eq("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/priority_encoder_4_2.md
Name: priority_encoder_4_2

Overview:
- Registered 4-to-2 priority encoder with request latching and a valid/ack handshake. It is the inverse of the team's 2-to-4 enabled decoder.
- It captures one-hot or multi-hot request lines, holds them as pending, and presents the highest-priority pending index as a 2-bit code.
- The code stays stable until the consumer acknowledges it.
- Sits on the request side of decoder-driven select logic, e.g. returning a line index to a controller that regenerates the select via the decoder.

Parameters:
- A_W, 2, code width; number of request lines N = 2**A_W (default 4). All behaviour below is stated for A_W=2 and scales directly.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  request-capture enable; when 0, y is ignored
- y  in  4  request lines; bit i requests code i
- a  out  2  encoded index of the presented request
- valid  out  1  a holds a valid presented code
- ack  in  1  consumer accepts the presented code
- pending  out  4  registered pending-request vector

Behaviour:
- One clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: pending=4'b0000, a=2'b00, valid=0, state=IDLE. Reset asserted mid-presentation drops valid immediately (asynchronously) and discards all pending requests.
- Capture:
  - Each edge: pending_next = (pending & ~clr) | (en ? y : 4'b0000).
  - clr is one-hot at index a only when state=PRESENT and ack=1; otherwise 0.
  - Set beats clear: if y[a] is high with en=1 in the ack cycle, pending[a] stays 1.
- Priority: bit 3 highest, bit 0 lowest. Code = index of the highest set bit of pending.
- State machine (2 states):
  - IDLE: valid=0.
    - If pending != 0 at the edge: load a with the priority code of the current pending, set valid=1, go to PRESENT.
    - ack is ignored in IDLE.
  - PRESENT: valid=1; a is frozen.
    - New requests, including higher-priority ones, only update pending; they never change a while presenting.
    - On an edge with ack=1: clear pending[a] (subject to set-beats-clear), valid=0, go to IDLE.
- Latency:
  - A request sampled at edge k sets pending at k; valid rises at edge k+1.
  - After ack at edge m, the next presentation occurs at m+1 at the earliest (valid low for exactly one cycle between back-to-back codes).
  - Maximum throughput is one code per 2 cycles.
- Level-held requests re-arm after service (y[i] held high while en=1 is re-presented). Consumers deassert y[i] or en to avoid repeats.
- en=0 freezes capture only; the presentation/ack path keeps running on existing pending bits.
- pending is never cleared except by ack or reset; no wrap or overflow (it is a bit vector, one request per line).

Test Plan:
- Reset: drive rst_n=0 mid-cycle while valid=1 -> valid=0, a=00, pending=0000 immediately, without waiting for a clk edge; stays IDLE after release with y=0.
- Single request: en=1, y=0100 pulsed one cycle -> pending=0100 after edge k; a=10, valid=1 after edge k+1; ack=1 one cycle -> valid=0, pending=0000.
- Multi-hot priority: en=1, y=1011 pulsed -> presented in order a=11, a=01, a=00. Each is held until ack, with valid low one cycle between codes; pending goes 1011 -> 0011 -> 0001 -> 0000.
- Preemption blocked: while presenting a=00, pulse y=1000 -> a stays 00 until ack, pending=1001; next presentation a=11.
- Enable gating: en=0, y=1111 for 5 cycles -> pending=0000, valid=0. Then en=1 with y=0010 -> a=01.
- Set beats clear: presenting a=01 with y=0010 and en=1 held during the ack cycle -> pending[1] stays 1; a=01 is presented again after one idle cycle.
